// File: rtl/mmio_master_if.sv
// Core request/response and peripheral bus signals of mmio_master.
// The master modport is the block's view; slave is the environment's view.
interface mmio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, bus_addr, bus_wdata, bus_we
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, bus_addr, bus_wdata, bus_we
    );
endinterface

// File: rtl/mmio_master.sv
// Single-outstanding MMIO master: byte/halfword/word loads and stores on a word bus,
// sub-word stores by read-modify-write. Define MMIO_MISALIGN_TRAP_EN to reject misaligned accesses.
module mmio_master #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset,
    mmio_master_if.master mif
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic             r_unsigned;
    logic [1:0]       r_size;
    logic [1:0]       r_lane;
    logic [DW-1:0]    r_wdata;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [DW-1:0]    r_resp_rdata;
    logic [DW-1:0]    r_bus_addr;
    logic [DW-1:0]    r_bus_wdata;
    logic             r_bus_we;

    logic             w_err;
    logic             w_last;
    logic [DW-1:0]    w_load_data;
    logic [DW-1:0]    w_merge_data;

    // Lane extraction and extension of a sampled bus word for loads.
    function automatic logic [DW-1:0] f_load(input logic [DW-1:0] d, input logic [1:0] sz,
                                             input logic [1:0] ln, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{ln, 3'b000} +: 8];
        h = ln[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   f_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   f_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: f_load = d;
        endcase
    endfunction

    // Replace only the addressed lane of the sampled word with the store data.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] d, input logic [DW-1:0] wd,
                                              input logic [1:0] sz, input logic [1:0] ln);
        f_merge = d;
        if (sz == 2'b00)
            f_merge[{ln, 3'b000} +: 8] = wd[7:0];
        else if (sz == 2'b01)
            f_merge[{ln[1], 4'b0000} +: 16] = wd[15:0];
    endfunction

    always_comb begin
        w_err = (mif.req_size == 2'b11);
`ifdef MMIO_MISALIGN_TRAP_EN
        if (mif.req_size == 2'b01 && mif.req_addr[0])
            w_err = 1'b1;
        if (mif.req_size == 2'b10 && mif.req_addr[1:0] != 2'b00)
            w_err = 1'b1;
`endif
    end

    assign w_last       = (r_cnt == '0);
    assign w_load_data  = f_load(mif.bus_rdata, r_size, r_lane, r_unsigned);
    assign w_merge_data = f_merge(mif.bus_rdata, r_wdata, r_size, r_lane);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_we     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_bus_we     <= 1'b0;
            case (r_state)
                IDLE: if (mif.req_valid) begin
                    r_we         <= mif.req_we;
                    r_unsigned   <= mif.req_unsigned;
                    r_size       <= mif.req_size;
                    r_lane       <= mif.req_addr[1:0];
                    r_wdata      <= mif.req_wdata;
                    r_bus_addr   <= {mif.req_addr[31:2], 2'b00};
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b0;
                    r_cnt        <= CNT_W'(WAIT_STATES);
                    if (w_err) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                    end else if (mif.req_we && mif.req_size == 2'b10) begin
                        r_state     <= WR;
                        r_bus_wdata <= mif.req_wdata;
                        r_bus_we    <= (WAIT_STATES == 0);
                    end else begin
                        r_state <= RD;
                    end
                end
                RD: if (w_last) begin
                    if (r_we) begin
                        r_state     <= WR;
                        r_bus_wdata <= w_merge_data;
                        r_cnt       <= CNT_W'(WAIT_STATES);
                        r_bus_we    <= (WAIT_STATES == 0);
                    end else begin
                        r_state      <= RESP;
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                // bus_we is registered, so it is raised one cycle ahead of the final WR cycle.
                WR: if (w_last) begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt - CNT_W'(1);
                    r_bus_we <= (r_cnt == CNT_W'(1));
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_resp_err  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mif.req_ready  = r_req_ready;
    assign mif.resp_valid = r_resp_valid;
    assign mif.resp_rdata = r_resp_rdata;
    assign mif.resp_err   = r_resp_err;
    assign mif.bus_addr   = r_bus_addr;
    assign mif.bus_wdata  = r_bus_wdata;
    assign mif.bus_we     = r_bus_we;
endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: one instance with WAIT_STATES=0 and one with WAIT_STATES=3.
module tb_mmio_master;
    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] bus_rdata;
    int          n_cmp;
    int          n_fail;

    mmio_master_if if0();
    mmio_master_if if3();

    assign if0.req_valid    = req_valid & ~sel;
    assign if3.req_valid    = req_valid & sel;
    assign if0.req_we       = req_we;
    assign if3.req_we       = req_we;
    assign if0.req_size     = req_size;
    assign if3.req_size     = req_size;
    assign if0.req_unsigned = req_unsigned;
    assign if3.req_unsigned = req_unsigned;
    assign if0.req_addr     = req_addr;
    assign if3.req_addr     = req_addr;
    assign if0.req_wdata    = req_wdata;
    assign if3.req_wdata    = req_wdata;
    assign if0.bus_rdata    = bus_rdata;
    assign if3.bus_rdata    = bus_rdata;

    mmio_master #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .reset(reset), .mif(if0.master));
    mmio_master #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .reset(reset), .mif(if3.master));

    logic        o_ready, o_rvalid, o_rerr, o_we;
    logic [31:0] o_rdata, o_addr, o_wdata;
    assign o_ready  = sel ? if3.req_ready  : if0.req_ready;
    assign o_rvalid = sel ? if3.resp_valid : if0.resp_valid;
    assign o_rerr   = sel ? if3.resp_err   : if0.resp_err;
    assign o_rdata  = sel ? if3.resp_rdata : if0.resp_rdata;
    assign o_we     = sel ? if3.bus_we     : if0.bus_we;
    assign o_addr   = sel ? if3.bus_addr   : if0.bus_addr;
    assign o_wdata  = sel ? if3.bus_wdata  : if0.bus_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch up to 20 cycles; cycle k is sampled at the k-th falling edge after acceptance.
    task automatic access(input logic sel_i, input logic we_i, input logic [1:0] sz_i,
                          input logic uns_i, input logic [31:0] addr_i, input logic [31:0] wdata_i,
                          input bit hold, output int lat, output int we_cnt, output int we_cyc,
                          output logic [31:0] we_addr, output logic [31:0] we_data,
                          output logic [31:0] rdata, output logic err);
        lat = -1; we_cnt = 0; we_cyc = -1; we_addr = '0; we_data = '0; rdata = '0; err = 1'b0;
        @(negedge clk);
        sel = sel_i; req_we = we_i; req_size = sz_i; req_unsigned = uns_i;
        req_addr = addr_i; req_wdata = wdata_i; req_valid = 1'b1;
        #1 chk("ready_before_access", 32'(o_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (o_we) begin
                we_cnt++;
                if (we_cyc < 0) begin we_cyc = k; we_addr = o_addr; we_data = o_wdata; end
            end
            if (o_rvalid) begin lat = k; rdata = o_rdata; err = o_rerr; end
            if (!hold || lat >= 0) req_valid = 1'b0;
        end
    endtask

    int          lat, wc, wcy;
    logic [31:0] wa, wd, rd;
    logic        er;
    int          stray;

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready0", 32'(if0.req_ready), 32'd1);
        chk("rst_rvalid0", 32'(if0.resp_valid), 32'd0);
        chk("rst_rerr0", 32'(if0.resp_err), 32'd0);
        chk("rst_rdata0", if0.resp_rdata, 32'h0);
        chk("rst_baddr0", if0.bus_addr, 32'h0);
        chk("rst_bwdata0", if0.bus_wdata, 32'h0);
        chk("rst_bwe0", 32'(if0.bus_we), 32'd0);
        chk("rst_ready3", 32'(if3.req_ready), 32'd1);
        reset = 1'b1;

        bus_rdata = 32'hDEADBEEF;
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("wload_lat", 32'(lat), 32'd2);
        chk("wload_data", rd, 32'hDEADBEEF);
        chk("wload_nowe", 32'(wc), 32'd0);
        chk("wload_err", 32'(er), 32'd0);
        chk("wload_baddr", if0.bus_addr, 32'h08);

        bus_rdata = 32'h80000000;
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("bload_s_lat", 32'(lat), 32'd2);
        chk("bload_s_data", rd, 32'hFFFFFF80);
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("bload_u_data", rd, 32'h00000080);

        bus_rdata = 32'h80011234;
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("hload_s_data", rd, 32'hFFFF8001);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("hload_lo_data", rd, 32'h00001234);

        bus_rdata = 32'h11223344;
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h05, 32'h000000AA, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("bstore_lat", 32'(lat), 32'd3);
        chk("bstore_wecnt", 32'(wc), 32'd1);
        chk("bstore_wecyc", 32'(wcy), 32'd2);
        chk("bstore_addr", wa, 32'h04);
        chk("bstore_data", wd, 32'h1122AA44);
        chk("bstore_rdata", rd, 32'h0);

        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("hstore_lat", 32'(lat), 32'd3);
        chk("hstore_addr", wa, 32'h0C);
        chk("hstore_data", wd, 32'hBEEF3344);

        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("wstore_lat", 32'(lat), 32'd2);
        chk("wstore_wecyc", 32'(wcy), 32'd1);
        chk("wstore_data", wd, 32'hCAFEF00D);
        chk("wstore_addr", wa, 32'h10);

        access(1'b1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h12345678, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("ws3_wstore_lat", 32'(lat), 32'd5);
        chk("ws3_wstore_wecnt", 32'(wc), 32'd1);
        chk("ws3_wstore_wecyc", 32'(wcy), 32'd4);
        chk("ws3_wstore_data", wd, 32'h12345678);

        bus_rdata = 32'h0BADF00D;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("ws3_wload_lat", 32'(lat), 32'd5);
        chk("ws3_wload_data", rd, 32'h0BADF00D);

        access(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h55, 1'b0, lat, wc, wcy, wa, wd, rd, er);
        chk("rsvd_lat", 32'(lat), 32'd1);
        chk("rsvd_err", 32'(er), 32'd1);
        chk("rsvd_rdata", rd, 32'h0);
        chk("rsvd_nowe", 32'(wc), 32'd0);

        bus_rdata = 32'h55667788;
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
`ifdef MMIO_MISALIGN_TRAP_EN
        chk("misw_lat", 32'(lat), 32'd1);
        chk("misw_err", 32'(er), 32'd1);
        chk("misw_rdata", rd, 32'h0);
`else
        chk("misw_lat", 32'(lat), 32'd2);
        chk("misw_err", 32'(er), 32'd0);
        chk("misw_rdata", rd, 32'h55667788);
`endif
        bus_rdata = 32'hA1B2C3D4;
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h03, 32'h0, 1'b0, lat, wc, wcy, wa, wd, rd, er);
`ifdef MMIO_MISALIGN_TRAP_EN
        chk("mish_err", 32'(er), 32'd1);
        chk("mish_rdata", rd, 32'h0);
`else
        chk("mish_err", 32'(er), 32'd0);
        chk("mish_rdata", rd, 32'h0000A1B2);
`endif

        // req_valid held through RD and RESP must not start a second access.
        bus_rdata = 32'h01020304;
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h01, 32'h0, 1'b1, lat, wc, wcy, wa, wd, rd, er);
        chk("hold_lat", 32'(lat), 32'd2);
        chk("hold_data", rd, 32'h00000003);
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_rvalid || o_we) stray++;
        end
        chk("hold_no_requeue", 32'(stray), 32'd0);
        chk("hold_ready", 32'(o_ready), 32'd1);

        // Reset in the middle of the RD phase of a byte store.
        bus_rdata = 32'h11223344;
        @(negedge clk);
        sel = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h05; req_wdata = 32'hAA; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_busy", 32'(o_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_rvalid", 32'(o_rvalid), 32'd0);
        chk("midrst_bwe", 32'(o_we), 32'd0);
        chk("midrst_baddr", o_addr, 32'h0);
        chk("midrst_bwdata", o_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_rvalid || o_we) stray++;
        end
        chk("midrst_no_activity", 32'(stray), 32'd0);
        chk("midrst_ready_after", 32'(o_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
